// File: rtl/uart_core.sv
// rtl/uart_core.sv - full-duplex UART: shared baud tick generator, transmitter, oversampling receiver
module uart_core #(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              uart_en,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [1:0]        data_len,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              stop2,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_o,
  output logic              tx_busy,
  input  logic              rx_i,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_busy,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  localparam int PH_W = $clog2(OVERSAMPLE);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // Data bits per frame, clamped so a narrow build never indexes past its data width.
  function automatic logic [3:0] frame_bits(input logic [1:0] len);
    logic [3:0] n;
    n = 4'd5 + {2'b00, len};
    if (n > 4'(DATA_W)) n = 4'(DATA_W);
    return n;
  endfunction

  // ---------------------------------------------------------------- baud tick
  logic [DIV_W-1:0] tick_cnt;
  logic             tick_run;
  logic             tick;

  // The tick keeps running while a frame is still in flight so that
  // dropping uart_en lets the current frame finish instead of stalling it.
  assign tick_run = uart_en || tx_busy || rx_busy;
  assign tick     = tick_run && (tick_cnt == baud_div);

  // Free-running divider, parked at zero whenever nothing needs ticks.
  always_ff @(posedge clock) begin
    if (reset || !tick_run || tick) tick_cnt <= '0;
    else                            tick_cnt <= tick_cnt + 1'b1;
  end

  // ---------------------------------------------------------------- transmitter
  state_t            tx_state, tx_next;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] tx_mask;
  logic [3:0]        tx_nbits;
  logic              tx_par_en, tx_stop2, tx_par_bit;
  logic [PH_W-1:0]   tx_phase;
  logic [2:0]        tx_bit;
  logic              tx_accept, tx_bit_end, tx_last_data, tx_last_stop;

  assign tx_ready     = uart_en && (tx_state == S_IDLE);
  assign tx_accept    = tx_valid && tx_ready;
  assign tx_busy      = (tx_state != S_IDLE);
  assign tx_bit_end   = tick && (tx_phase == PH_LAST);
  assign tx_last_data = ({1'b0, tx_bit} == tx_nbits - 4'd1);
  assign tx_last_stop = (tx_bit[0] == tx_stop2);
  assign tx_mask      = DATA_W'((32'd1 << frame_bits(data_len)) - 32'd1);

  // TX state register.
  always_ff @(posedge clock) begin
    if (reset) tx_state <= S_IDLE;
    else       tx_state <= tx_next;
  end

  // TX next-state: every bit lasts OVERSAMPLE ticks; parity state only when enabled.
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      S_IDLE:   if (tx_accept) tx_next = S_START;
      S_START:  if (tx_bit_end) tx_next = S_DATA;
      S_DATA:   if (tx_bit_end && tx_last_data) tx_next = tx_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (tx_bit_end) tx_next = S_STOP;
      S_STOP:   if (tx_bit_end && tx_last_stop) tx_next = S_IDLE;
      default:  tx_next = S_IDLE;
    endcase
  end

  // Serial line level decoded from the current state; idle and stop are high.
  always_comb begin
    tx_o = 1'b1;
    case (tx_state)
      S_START:  tx_o = 1'b0;
      S_DATA:   tx_o = tx_shift[0];
      S_PARITY: tx_o = tx_par_bit;
      default:  tx_o = 1'b1;
    endcase
  end

  // TX datapath: latch byte and format on accept, then step phase/bit counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_shift   <= '0;
      tx_nbits   <= 4'd5;
      tx_par_en  <= 1'b0;
      tx_stop2   <= 1'b0;
      tx_par_bit <= 1'b0;
      tx_phase   <= '0;
      tx_bit     <= '0;
    end else if (tx_accept) begin
      tx_shift   <= tx_data;
      tx_nbits   <= frame_bits(data_len);
      tx_par_en  <= parity_en;
      tx_stop2   <= stop2;
      tx_par_bit <= (^(tx_data & tx_mask)) ^ parity_odd;
      tx_phase   <= '0;
      tx_bit     <= '0;
    end else if (tick && tx_state != S_IDLE) begin
      tx_phase <= tx_phase + 1'b1;
      if (tx_bit_end) begin
        tx_phase <= '0;
        if (tx_state == S_DATA) begin
          tx_shift <= tx_shift >> 1;
          tx_bit   <= tx_last_data ? 3'd0 : tx_bit + 3'd1;
        end else if (tx_state == S_STOP) begin
          tx_bit <= tx_bit + 3'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- receiver
  state_t            rx_state, rx_next;
  logic              rx_s1, rx_s2, rx_prev;
  logic [DATA_W-1:0] rx_shift;
  logic [3:0]        rx_nbits;
  logic [3:0]        rx_align;
  logic              rx_par_en, rx_stop2;
  logic              rx_par, rx_perr, rx_ferr;
  logic [PH_W-1:0]   rx_phase;
  logic [2:0]        rx_bit;
  logic              rx_start, rx_half, rx_samp, rx_last_data, rx_done;

  assign rx_busy      = (rx_state != S_IDLE);
  assign rx_start     = (rx_state == S_IDLE) && uart_en && rx_prev && !rx_s2;
  assign rx_half      = tick && (rx_phase == PH_HALF);
  assign rx_samp      = tick && (rx_phase == PH_LAST);
  assign rx_last_data = ({1'b0, rx_bit} == rx_nbits - 4'd1);
  assign rx_done      = (rx_state == S_STOP) && rx_samp && (rx_bit[0] == rx_stop2);
  assign rx_align     = 4'(DATA_W) - rx_nbits;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_i;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // RX state register.
  always_ff @(posedge clock) begin
    if (reset) rx_state <= S_IDLE;
    else       rx_state <= rx_next;
  end

  // RX next-state: half-bit check of the start bit, then mid-bit samples.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      S_IDLE:   if (rx_start) rx_next = S_START;
      S_START:  if (rx_half) rx_next = rx_s2 ? S_IDLE : S_DATA;
      S_DATA:   if (rx_samp && rx_last_data) rx_next = rx_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (rx_samp) rx_next = S_STOP;
      S_STOP:   if (rx_done) rx_next = S_IDLE;
      default:  rx_next = S_IDLE;
    endcase
  end

  // RX datapath: shift data in from the top, accumulate parity and stop errors.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_shift  <= '0;
      rx_nbits  <= 4'd5;
      rx_par_en <= 1'b0;
      rx_stop2  <= 1'b0;
      rx_par    <= 1'b0;
      rx_perr   <= 1'b0;
      rx_ferr   <= 1'b0;
      rx_phase  <= '0;
      rx_bit    <= '0;
    end else if (rx_start) begin
      rx_shift  <= '0;
      rx_nbits  <= frame_bits(data_len);
      rx_par_en <= parity_en;
      rx_stop2  <= stop2;
      rx_par    <= parity_odd;
      rx_perr   <= 1'b0;
      rx_ferr   <= 1'b0;
      rx_phase  <= '0;
      rx_bit    <= '0;
    end else if (tick && rx_state != S_IDLE) begin
      rx_phase <= rx_phase + 1'b1;
      if (rx_state == S_START) begin
        if (rx_half) rx_phase <= '0;
      end else if (rx_samp) begin
        rx_phase <= '0;
        case (rx_state)
          S_DATA: begin
            rx_shift <= {rx_s2, rx_shift[DATA_W-1:1]};
            rx_par   <= rx_par ^ rx_s2;
            rx_bit   <= rx_last_data ? 3'd0 : rx_bit + 3'd1;
          end
          S_PARITY: rx_perr <= rx_par ^ rx_s2;
          S_STOP: begin
            if (!rx_s2) rx_ferr <= 1'b1;
            rx_bit <= rx_bit + 3'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Frame completion: deliver the byte or flag overrun, pulse error strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      parity_err <= rx_done && rx_perr;
      frame_err  <= rx_done && (rx_ferr || !rx_s2);
      overrun    <= rx_done && rx_valid;
      if (rx_done && !rx_valid) begin
        rx_data  <= rx_shift >> rx_align;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// tb/tb_uart_core.sv - directed bench for uart_core
module tb_uart_core;

  logic       clock = 1'b0;
  logic       reset, uart_en;
  logic [15:0] baud_div;
  logic [1:0] data_len;
  logic       parity_en, parity_odd, stop2;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, tx_o, tx_busy;
  logic       rx_i;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready, rx_busy;
  logic       parity_err, frame_err, overrun;

  logic       loop_en, rx_drv;
  int         n_cmp, n_bad;
  logic [255:0] wave;
  int         flen, pe_n, fe_n, ov_n;
  logic       rdy_seen, busy_seen, val_seen;

  assign rx_i = loop_en ? tx_o : rx_drv;

  always #5 clock = ~clock;

  uart_core dut (
    .clock(clock), .reset(reset), .uart_en(uart_en), .baud_div(baud_div),
    .data_len(data_len), .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_o(tx_o), .tx_busy(tx_busy),
    .rx_i(rx_i), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_busy(rx_busy),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-clock line level expected for a frame whose bits (LSB first) each last 16 clocks.
  function automatic logic [255:0] exp_wave(input logic [15:0] bits, input int n);
    logic [255:0] w;
    w = '0;
    for (int k = 0; k < n * 16; k++) w[k] = bits[k / 16];
    return w;
  endfunction

  task automatic tally();
    if (parity_err) pe_n++;
    if (frame_err)  fe_n++;
    if (overrun)    ov_n++;
    if (rx_busy)    busy_seen = 1'b1;
    if (rx_valid)   val_seen = 1'b1;
  endtask

  // Hand one byte to the transmitter and record tx_o each clock until it goes idle.
  task automatic send_frame(input logic [7:0] b);
    @(negedge clock);
    tx_data = b; tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    wave = '0; flen = -1; rdy_seen = 1'b0;
    pe_n = 0; fe_n = 0; ov_n = 0; busy_seen = 1'b0; val_seen = 1'b0;
    for (int k = 0; k < 256; k++) begin
      if (k > 0) @(negedge clock);
      if (!tx_busy) begin
        flen = k;
        break;
      end
      wave[k] = tx_o;
      rdy_seen = rdy_seen | tx_ready;
      tally();
    end
  endtask

  // Drive rx_drv with n bits of per clocks each, then idle high for 48 clocks.
  task automatic drive_rx(input logic [15:0] bits, input int n, input int per);
    pe_n = 0; fe_n = 0; ov_n = 0; busy_seen = 1'b0; val_seen = 1'b0;
    for (int k = 0; k < n * per + 48; k++) begin
      @(negedge clock);
      rx_drv = (k < n * per) ? bits[k / per] : 1'b1;
      tally();
    end
  endtask

  task automatic pop();
    @(negedge clock);
    rx_ready = 1'b1;
    @(negedge clock);
    rx_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1; uart_en = 1'b1; baud_div = 16'd0;
    data_len = 2'd3; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
    loop_en = 1'b0; rx_drv = 1'b1;
    repeat (3) @(negedge clock);

    chk("reset_tx_o", tx_o, 1'b1);
    chk("reset_busy", {tx_busy, rx_busy}, 2'b00);
    chk("reset_rx_valid", rx_valid, 1'b0);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_strobes", {parity_err, frame_err, overrun}, 3'b000);
    chk("reset_tx_ready", tx_ready, 1'b1);
    reset = 1'b0;

    // 8N1 0xA5 waveform, no loopback
    send_frame(8'hA5);
    chk("8n1_wave", wave, exp_wave({1'b1, 8'hA5, 1'b0}, 10));
    chk("8n1_len", flen, 160);
    chk("8n1_ready_low", rdy_seen, 1'b0);
    chk("8n1_ready_after", tx_ready, 1'b1);

    // 8E2 loopback
    loop_en = 1'b1; parity_en = 1'b1; parity_odd = 1'b0; stop2 = 1'b1;
    send_frame(8'hA5);
    chk("8e2_parity_bit", wave[152], 1'b0);
    chk("8e2_wave", wave, exp_wave({2'b11, 1'b0, 8'hA5, 1'b0}, 12));
    chk("8e2_len", flen, 192);
    chk("8e2_rx_valid", rx_valid, 1'b1);
    chk("8e2_rx_data", rx_data, 8'hA5);
    chk("8e2_errs", pe_n + fe_n + ov_n, 0);
    pop();
    chk("8e2_pop", rx_valid, 1'b0);

    // 8O1 loopback
    parity_odd = 1'b1; stop2 = 1'b0;
    send_frame(8'hA5);
    chk("8o1_parity_bit", wave[152], 1'b1);
    chk("8o1_wave", wave, exp_wave({1'b1, 1'b1, 8'hA5, 1'b0}, 11));
    chk("8o1_rx_data", rx_data, 8'hA5);
    chk("8o1_errs", pe_n + fe_n + ov_n, 0);
    pop();

    // 5N1 loopback, upper bits of the byte are not sent
    data_len = 2'd0; parity_en = 1'b0; parity_odd = 1'b0;
    send_frame(8'hFF);
    chk("5n1_wave", wave, exp_wave({1'b1, 5'h1F, 1'b0}, 7));
    chk("5n1_len", flen, 112);
    chk("5n1_rx_data", rx_data, 8'h1F);
    pop();

    // 6-clock glitch is a false start
    loop_en = 1'b0; data_len = 2'd3;
    drive_rx(16'h0000, 1, 6);
    chk("glitch_busy_seen", busy_seen, 1'b1);
    chk("glitch_no_valid", val_seen, 1'b0);
    chk("glitch_no_strobes", pe_n + fe_n + ov_n, 0);
    chk("glitch_idle", rx_busy, 1'b0);

    // stop bit sampled low
    drive_rx({1'b0, 8'h3C, 1'b0}, 10, 16);
    chk("ferr_count", fe_n, 1);
    chk("ferr_no_perr", pe_n, 0);
    chk("ferr_rx_data", rx_data, 8'h3C);
    pop();

    // even parity with the parity bit flipped
    parity_en = 1'b1;
    drive_rx({1'b1, 1'b1, 8'h3C, 1'b0}, 11, 16);
    chk("perr_count", pe_n, 1);
    chk("perr_no_ferr", fe_n, 0);
    pop();

    // two frames with no consumer: second one overruns
    parity_en = 1'b0;
    drive_rx({1'b1, 8'h11, 1'b0}, 10, 16);
    chk("ovr_first_valid", rx_valid, 1'b1);
    chk("ovr_first_data", rx_data, 8'h11);
    chk("ovr_first_none", ov_n, 0);
    drive_rx({1'b1, 8'h22, 1'b0}, 10, 16);
    chk("ovr_count", ov_n, 1);
    chk("ovr_data_kept", rx_data, 8'h11);
    chk("ovr_still_valid", rx_valid, 1'b1);
    pop();

    // disabled core accepts nothing and ignores a start bit
    uart_en = 1'b0;
    @(negedge clock);
    chk("dis_tx_ready", tx_ready, 1'b0);
    drive_rx({1'b1, 8'h55, 1'b0}, 10, 16);
    chk("dis_rx_busy", busy_seen, 1'b0);
    chk("dis_rx_valid", val_seen, 1'b0);
    uart_en = 1'b1;

    // reset in the middle of a data bit
    @(negedge clock);
    tx_data = 8'h00; tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    repeat (40) @(negedge clock);
    chk("rst_mid_low", tx_o, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_mid_tx_o", tx_o, 1'b1);
    chk("rst_mid_busy", tx_busy, 1'b0);
    chk("rst_mid_strobes", {parity_err, frame_err, overrun}, 3'b000);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
